mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Next-generation memory pipeline stage for the ARM core. It sits between EXE/MEM and MEM/WB.
- Replaces the fixed single-cycle internal memory with a request/ready handshake to an external, variable-latency memory port (SRAM or cache).
- Adds byte/word access sizes and byte enables.
- Asserts freeze upstream until each access completes.

Parameters:
- DATA_W, 32, data/word width; must be a multiple of 8.
- ADDR_W, 32, external address width.
- DST_W, 4, destination register index width.
- BASE_ADDR, 1024, data-memory base; subtracted from the ALU address before issue.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request from EXE/MEM.
- mem_write  in  1  store request from EXE/MEM.
- size_byte  in  1  1 = byte access, 0 = word access.
- WB_en  in  1  writeback enable.
- dst  in  DST_W  destination register.
- ALU_res  in  DATA_W  effective address / ALU result.
- val_Rm  in  DATA_W  store data.
- freeze  out  1  stall for IF..EXE/MEM registers.
- mem_read_out  out  1  load valid to MEM/WB.
- WB_en_out  out  1  writeback enable to MEM/WB.
- dst_out  out  DST_W  destination register.
- ALU_res_out  out  DATA_W  ALU result.
- mem_out  out  DATA_W  load data.
- align_fault  out  1  misaligned word access pulse.
- ext_req  out  1  external request.
- ext_we  out  1  external write.
- ext_addr  out  ADDR_W  external byte address.
- ext_wdata  out  DATA_W  external write data.
- ext_be  out  DATA_W/8  byte enables.
- ext_ready  in  1  access complete / read data valid.
- ext_rdata  in  DATA_W  external read data.

Behaviour:
- FSM states:
  - IDLE: access = mem_read|mem_write. If access, latch request (address, wdata, be, we, size, byte lane), freeze=1, go BUSY.
  - BUSY: ext_req=1, request fields held stable. freeze=1. On ext_ready: capture read data into data_q, go DONE. Otherwise stay in BUSY, with no timeout.
  - DONE: freeze=0, ext_req=0, result visible; go IDLE.
- Minimum access takes 3 cycles (freeze high 2 cycles). Each BUSY cycle without ready adds one cycle.
- The upstream register holds its inputs while freeze=1. Back-to-back accesses therefore re-enter IDLE→BUSY after DONE.
- Request fields:
  - ext_addr = ALU_res - BASE_ADDR.
  - Word access: low log2(DATA_W/8) bits of ext_addr are forced to 0, ext_be all ones, ext_wdata = val_Rm.
  - Byte access: ext_be is one-hot at the byte lane, and ext_wdata replicates val_Rm[7:0] in every lane.
  - Load data: word → data_q = ext_rdata; byte → the selected lane, zero-extended.
- Pass-through and output rules:
  - dst_out, ALU_res_out: combinational pass-through.
  - WB_en_out = WB_en & ~freeze; mem_read_out = mem_read & ~freeze. This gives MEM/WB a bubble while stalled.
  - mem_out = data_q.
- mem_read & mem_write together: the write wins and no read data is captured; data_q keeps its prior value.
- ext_ready is ignored in IDLE and DONE.
- No access present: freeze=0 and the stage is fully transparent.
- Reset (async, any state, including mid-BUSY):
  - state = IDLE; ext_req, ext_we, align_fault = 0; latched request = 0; data_q = 0.
  - Pending external transaction is abandoned.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A word access with nonzero low address bits in IDLE issues no request and stays in IDLE.
  - freeze=0; align_fault=1 for that one cycle.
  - WB_en_out and mem_read_out forced 0 for that cycle.
- Undefined: align_fault is tied to 0 and the low bits are silently masked.

Decomposition:
- Shared package/constants header holds:
  - WORD_WIDTH, REG_FILE_DEPTH defaults.
  - mem state enum (IDLE/BUSY/DONE).
  - Size encoding.
- Natural sub-module: mem_lane_align. It is combinational and produces be, replicated wdata, and the extracted/zero-extended read data from size and the lane.

Test Plan:
1. Word load:
   - Stimulus: ALU_res=0x408, ready on first BUSY cycle, ext_rdata=0xDEADBEEF.
   - Response: ext_addr=0x8, be=0xF, freeze high 2 cycles, mem_out=0xDEADBEEF, WB_en_out=1 in DONE.
2. Byte store:
   - Stimulus: ALU_res=0x403, val_Rm=0x12345678.
   - Response: ext_we=1, ext_addr=0x3, be=0x8, wdata=0x78787878.
3. Byte load, 4 wait cycles:
   - Stimulus: ALU_res=0x401, ext_rdata=0x11223344 after 4 wait cycles.
   - Response: freeze high 6 cycles, mem_out=0x00000033.
4. Reset mid-BUSY:
   - Stimulus: assert rst while ext_req=1.
   - Response: ext_req and freeze drop the same cycle; mem_out=0; next access restarts cleanly.
5. Simultaneous read+write:
   - Stimulus: mem_read=1, mem_write=1.
   - Response: ext_we=1; mem_out unchanged.
6. Misaligned word, MEM_ALIGN_CHECK_EN defined:
   - Stimulus: word access at ALU_res=0x402.
   - Response: align_fault=1 one cycle, ext_req stays 0, WB_en_out=0.

Source files
------------

// File: rtl/mem_stage_hs_pkg.sv
// Shared constants and types for the memory stage with external handshake.
// Holds default widths, the access FSM state encoding and the size encoding.
// Imported by mem_stage_hs and mem_lane_align.
package mem_stage_hs_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_FILE_DEPTH = 16;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Access size encoding (matches the size_byte port)
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, replicated store data and load extraction.
// Purely combinational, zero latency.
// No flow control; outputs follow size/lane/data inputs directly.
module mem_lane_align
  import mem_stage_hs_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH,
  parameter int LANE_W = 2
) (
  input  logic                  size_byte,
  input  logic [LANE_W-1:0]     lane,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     rdata,
  output logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     wdata_rep,
  output logic [DATA_W-1:0]     rdata_ext
);

  localparam int NB = DATA_W / 8;

  // Word accesses use the full bus; byte accesses touch one lane only
  always_comb begin
    be        = '1;
    wdata_rep = wdata;
    rdata_ext = rdata;
    if (size_byte == SIZE_BYTE) begin
      be            = '0;
      be[lane]      = 1'b1;
      wdata_rep     = {NB{wdata[7:0]}};
      rdata_ext     = '0;
      rdata_ext[7:0] = rdata[lane*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage driving a variable-latency external port via req/ready.
// Latency: 3 cycles minimum (IDLE, BUSY, DONE), +1 per BUSY cycle without ready.
// Backpressure: freeze stalls upstream from access accept until ready; optional
// misaligned-word trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int DATA_W    = WORD_WIDTH,
  parameter int ADDR_W    = 32,
  parameter int DST_W     = $clog2(REG_FILE_DEPTH),
  parameter int BASE_ADDR = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                size_byte,
  input  logic                WB_en,
  input  logic [DST_W-1:0]    dst,
  input  logic [DATA_W-1:0]   ALU_res,
  input  logic [DATA_W-1:0]   val_Rm,
  output logic                freeze,
  output logic                mem_read_out,
  output logic                WB_en_out,
  output logic [DST_W-1:0]    dst_out,
  output logic [DATA_W-1:0]   ALU_res_out,
  output logic [DATA_W-1:0]   mem_out,
  output logic                align_fault,
  output logic                ext_req,
  output logic                ext_we,
  output logic [ADDR_W-1:0]   ext_addr,
  output logic [DATA_W-1:0]   ext_wdata,
  output logic [DATA_W/8-1:0] ext_be,
  input  logic                ext_ready,
  input  logic [DATA_W-1:0]   ext_rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;

  mem_state_t          state;
  logic                req_q;
  logic                we_q;
  logic                size_q;
  logic [LANE_W-1:0]   lane_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   data_q;

  logic                access;
  logic                fault;
  logic [ADDR_W-1:0]   addr_raw;
  logic [ADDR_W-1:0]   addr_word;
  logic [LANE_W-1:0]   lane_in;
  logic                size_sel;
  logic [LANE_W-1:0]   lane_sel;
  logic [NB-1:0]       be_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [DATA_W-1:0]   rdata_ext;

  assign access    = mem_read | mem_write;
  assign addr_raw  = ADDR_W'(ALU_res) - ADDR_W'(BASE_ADDR);
  assign addr_word = addr_raw & ~ADDR_W'(NB - 1);
  assign lane_in   = addr_raw[LANE_W-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned word access is refused in IDLE and flagged for one cycle
  assign fault = (state == ST_IDLE) && access && (size_byte == SIZE_WORD) &&
                 (lane_in != '0);
`else
  assign fault = 1'b0;
`endif

  // In IDLE the lane steering works on the live request (for latching);
  // afterwards it works on the latched request (for load extraction)
  assign size_sel = (state == ST_IDLE) ? size_byte : size_q;
  assign lane_sel = (state == ST_IDLE) ? lane_in : lane_q;

  mem_lane_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane (
    .size_byte (size_sel),
    .lane      (lane_sel),
    .wdata     (val_Rm),
    .rdata     (ext_rdata),
    .be        (be_nxt),
    .wdata_rep (wdata_nxt),
    .rdata_ext (rdata_ext)
  );

  // Access sequencer: latch request in IDLE, hold it in BUSY until ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 1'b0;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !fault) begin
            addr_q  <= (size_byte == SIZE_WORD) ? addr_word : addr_raw;
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
            we_q    <= mem_write;
            size_q  <= size_byte;
            lane_q  <= lane_in;
            req_q   <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (ext_ready) begin
            req_q <= 1'b0;
            // A store (including read+write) leaves the load data untouched
            if (!we_q) data_q <= rdata_ext;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign freeze       = ((state == ST_IDLE) && access && !fault) || (state == ST_BUSY);
  assign WB_en_out    = WB_en & ~freeze & ~fault;
  assign mem_read_out = mem_read & ~freeze & ~fault;
  assign dst_out      = dst;
  assign ALU_res_out  = ALU_res;
  assign mem_out      = data_q;
  assign align_fault  = fault;
  assign ext_req      = req_q;
  assign ext_we       = we_q;
  assign ext_addr     = addr_q;
  assign ext_wdata    = wdata_q;
  assign ext_be       = be_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed vector table, hand-written
// corner sequences (reset mid-access, idle transparency, misalignment) and
// randomized accesses scored against a behavioural model.
module tb_mem_stage_hs;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write, size_byte, WB_en;
  logic [3:0]  dst;
  logic [31:0] ALU_res, val_Rm;
  logic        freeze, mem_read_out, WB_en_out;
  logic [3:0]  dst_out;
  logic [31:0] ALU_res_out, mem_out;
  logic        align_fault, ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [3:0]  ext_be;
  logic        ext_ready;
  logic [31:0] ext_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] model_mem;

  mem_stage_hs dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size_byte    (size_byte),
    .WB_en        (WB_en),
    .dst          (dst),
    .ALU_res      (ALU_res),
    .val_Rm       (val_Rm),
    .freeze       (freeze),
    .mem_read_out (mem_read_out),
    .WB_en_out    (WB_en_out),
    .dst_out      (dst_out),
    .ALU_res_out  (ALU_res_out),
    .mem_out      (mem_out),
    .align_fault  (align_fault),
    .ext_req      (ext_req),
    .ext_we       (ext_we),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_be       (ext_be),
    .ext_ready    (ext_ready),
    .ext_rdata    (ext_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sz;
    logic [31:0] alu;
    logic [31:0] v;
    logic [31:0] rdat;
    int          waits;
    logic        wb;
    logic [3:0]  d;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_mem;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access starting in IDLE; ends in the IDLE cycle after DONE
  task automatic do_access(input string nm, input vec_t t);
    int fz;
    int unstable;
    unstable  = 0;
    mem_read  = t.rd;
    mem_write = t.wr;
    size_byte = t.sz;
    ALU_res   = t.alu;
    val_Rm    = t.v;
    WB_en     = t.wb;
    dst       = t.d;
    ext_ready = 1'b0;
    ext_rdata = $urandom;
    #1;
    fz = int'(freeze);
    chk({nm, "_idle_wb_bubble"}, WB_en_out, 0);
    chk({nm, "_idle_rd_bubble"}, mem_read_out, 0);
    chk({nm, "_idle_req"}, ext_req, 0);
    chk({nm, "_fault"}, align_fault, 0);
    chk({nm, "_dst_pass"}, dst_out, t.d);
    chk({nm, "_alu_pass"}, ALU_res_out, t.alu);
    next_cycle();
    for (int w = 0; w <= t.waits; w++) begin
      ext_ready = (w == t.waits);
      ext_rdata = (w == t.waits) ? t.rdat : $urandom;
      #1;
      if (w == 0) begin
        chk({nm, "_req"}, ext_req, 1);
        chk({nm, "_addr"}, ext_addr, t.e_addr);
        chk({nm, "_be"}, ext_be, t.e_be);
        chk({nm, "_wdata"}, ext_wdata, t.e_wd);
        chk({nm, "_we"}, ext_we, t.wr);
      end else if (ext_req !== 1'b1 || ext_addr !== t.e_addr || ext_be !== t.e_be ||
                   ext_wdata !== t.e_wd) begin
        unstable++;
      end
      fz += int'(freeze);
      next_cycle();
    end
    // DONE: ready is ignored here, so offer junk data
    ext_ready = 1'b1;
    ext_rdata = $urandom;
    #1;
    chk({nm, "_busy_stable"}, unstable, 0);
    chk({nm, "_freeze_cycles"}, fz, t.waits + 2);
    chk({nm, "_done_freeze"}, freeze, 0);
    chk({nm, "_done_req"}, ext_req, 0);
    chk({nm, "_mem_out"}, mem_out, t.e_mem);
    chk({nm, "_done_wb"}, WB_en_out, t.wb);
    chk({nm, "_done_rd"}, mem_read_out, t.rd);
    next_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    WB_en     = 1'b0;
    #1;
    chk({nm, "_after_mem_out"}, mem_out, t.e_mem);
    chk({nm, "_after_req"}, ext_req, 0);
    ext_ready = 1'b0;
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; size_byte = 0; WB_en = 0; dst = 0;
    ALU_res = 0; val_Rm = 0; ext_ready = 0; ext_rdata = 0;

    tbl[0] = '{1, 0, 0, 32'h408, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1, 4'd3,
               32'h8, 4'hF, 32'hCAFEF00D, 32'hDEADBEEF};
    tbl[1] = '{0, 1, 1, 32'h403, 32'h12345678, 32'h0, 0, 0, 4'd1,
               32'h3, 4'h8, 32'h78787878, 32'hDEADBEEF};
    tbl[2] = '{1, 0, 1, 32'h401, 32'h0, 32'h11223344, 4, 1, 4'd7,
               32'h1, 4'h2, 32'h0, 32'h00000033};
    tbl[3] = '{1, 1, 0, 32'h40C, 32'hA5A5A5A5, 32'h99999999, 1, 1, 4'd2,
               32'hC, 4'hF, 32'hA5A5A5A5, 32'h00000033};
    tbl[4] = '{1, 0, 1, 32'h407, 32'h000000FF, 32'h8899AABB, 2, 1, 4'd9,
               32'h7, 4'h8, 32'hFFFFFFFF, 32'h00000088};
    tbl[5] = '{0, 1, 0, 32'h400, 32'h01020304, 32'h0, 0, 0, 4'd0,
               32'h0, 4'hF, 32'h01020304, 32'h00000088};
    tbl[6] = '{1, 0, 0, 32'h410, 32'h0, 32'h0BADF00D, 3, 1, 4'd15,
               32'h10, 4'hF, 32'h0, 32'h0BADF00D};

    next_cycle();
    next_cycle();
    chk("rst_req", ext_req, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_mem_out", mem_out, 0);
    chk("rst_we", ext_we, 0);
    chk("rst_addr", ext_addr, 0);
    chk("rst_fault", align_fault, 0);
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) do_access($sformatf("vec%0d", i), tbl[i]);
    model_mem = 32'h0BADF00D;

    // Idle transparency with ready asserted (must be ignored)
    WB_en = 1; dst = 4'd5; ALU_res = 32'h1234; ext_ready = 1; ext_rdata = 32'hFFFFFFFF;
    #1;
    chk("idle_freeze", freeze, 0);
    chk("idle_wb", WB_en_out, 1);
    chk("idle_rd", mem_read_out, 0);
    chk("idle_dst", dst_out, 5);
    next_cycle();
    chk("idle_req", ext_req, 0);
    chk("idle_mem_out", mem_out, model_mem);
    ext_ready = 0; WB_en = 0;

    // Misaligned word access
`ifdef MEM_ALIGN_CHECK_EN
    mem_read = 1; size_byte = 0; ALU_res = 32'h402; WB_en = 1;
    #1;
    chk("mis_fault", align_fault, 1);
    chk("mis_freeze", freeze, 0);
    chk("mis_wb", WB_en_out, 0);
    chk("mis_rd", mem_read_out, 0);
    next_cycle();
    mem_read = 0; WB_en = 0;
    #1;
    chk("mis_req", ext_req, 0);
    chk("mis_fault_clear", align_fault, 0);
`else
    rv = '{1, 0, 0, 32'h402, 32'h0, 32'h55667788, 0, 1, 4'd4,
           32'h0, 4'hF, 32'h0, 32'h55667788};
    do_access("mis", rv);
    model_mem = 32'h55667788;
`endif

    // Reset in the middle of BUSY
    mem_read = 1; size_byte = 0; ALU_res = 32'h408; WB_en = 1;
    next_cycle();
    chk("rmid_req_before", ext_req, 1);
    rst = 1; mem_read = 0; WB_en = 0;
    #1;
    chk("rmid_req", ext_req, 0);
    chk("rmid_freeze", freeze, 0);
    chk("rmid_mem_out", mem_out, 0);
    next_cycle();
    rst = 0;
    next_cycle();
    rv = '{1, 0, 0, 32'h414, 32'h0, 32'h600DCAFE, 1, 1, 4'd6,
           32'h14, 4'hF, 32'h0, 32'h600DCAFE};
    do_access("rmid_clean", rv);
    model_mem = 32'h600DCAFE;

    // Randomized accesses against a behavioural model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] off;
      logic [1:0]  ln;
      rv.wr = 1'($urandom_range(0, 1));
      rv.rd = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.sz = 1'($urandom_range(0, 1));
      off   = $urandom_range(0, 16'hFFFF);
`ifdef MEM_ALIGN_CHECK_EN
      if (!rv.sz) off = off & ~32'h3;
`endif
      ln       = off[1:0];
      rv.alu   = 32'h400 + off;
      rv.v     = $urandom;
      rv.rdat  = $urandom;
      rv.waits = $urandom_range(0, 5);
      rv.wb    = 1'($urandom_range(0, 1));
      rv.d     = 4'($urandom_range(0, 15));
      rv.e_addr = rv.sz ? off : (off & ~32'h3);
      rv.e_be   = rv.sz ? (4'b0001 << ln) : 4'hF;
      rv.e_wd   = rv.sz ? {4{rv.v[7:0]}} : rv.v;
      if (rv.rd && !rv.wr)
        model_mem = rv.sz ? ((rv.rdat >> (8 * ln)) & 32'hFF) : rv.rdat;
      rv.e_mem = model_mem;
      do_access($sformatf("rnd%0d", i), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
